// File: rtl/motion_pkg.sv
// Motion codes and sequencer state shared by the H-bridge motion path.
package motion_pkg;

  localparam logic [2:0] MOT_REST      = 3'd0;
  localparam logic [2:0] MOT_FWD       = 3'd1;
  localparam logic [2:0] MOT_BACK      = 3'd2;
  localparam logic [2:0] MOT_RIGHT     = 3'd3;
  localparam logic [2:0] MOT_LEFT      = 3'd4;
  localparam logic [2:0] MOT_MAX_VALID = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StDeadtime,
    StRun
  } seq_state_e;

  // A coast gap is only needed when switching between two different driven directions.
  function automatic logic needs_deadtime(input logic [2:0] new_dir, input logic [2:0] last_dir);
    return (new_dir != MOT_REST) && (last_dir != MOT_REST) && (new_dir != last_dir);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every CLK_HZ/TICK_HZ clocks, counting from reset.
module tick_gen #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned Div  = CLK_HZ / TICK_HZ;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] Last = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == Last) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == Last);

endmodule

// File: rtl/motion_sequencer.sv
// Timed motion command sequencer with coast dead-time ahead of the H-bridge decoder.
// Optional PWM duty gating during RUN is enabled by defining MOTION_SEQ_PWM_EN.
module motion_sequencer #(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned TICK_HZ        = 1000,
  parameter int unsigned DUR_W          = 16,
  parameter int unsigned DEADTIME_TICKS = 50
`ifdef MOTION_SEQ_PWM_EN
  ,
  parameter int unsigned PWM_W          = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_dir,
  input  logic [DUR_W-1:0] cmd_dur,
`ifdef MOTION_SEQ_PWM_EN
  input  logic [PWM_W-1:0] cmd_speed,
`endif
  input  logic             abort,
  output logic [3:0]       motiondir,
  output logic             busy,
  output logic             done,
  output logic             err_bad_cmd
);

  import motion_pkg::*;

  localparam int unsigned DtW = $clog2(DEADTIME_TICKS + 1);

  seq_state_e       state_q, state_d;
  logic [DtW-1:0]   dt_cnt_q, dt_cnt_d;
  logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d;
  logic [2:0]       dir_q, dir_d;
  logic [2:0]       last_dir_q, last_dir_d;
  logic [3:0]       motiondir_q, motiondir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             tick;
  logic             accept;

`ifdef MOTION_SEQ_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0] speed_q, speed_d;
`endif

  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Held low through reset so nothing is accepted before the flops settle.
  assign cmd_ready = rst_n && (state_q == StIdle) && !abort;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d    = state_q;
    dt_cnt_d   = dt_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (cmd_dir > MOT_MAX_VALID) begin
            err_d = 1'b1;
          end else if (cmd_dur == '0) begin
            done_d = 1'b1;
          end else begin
            dir_d     = cmd_dir;
            dur_cnt_d = cmd_dur;
            if (needs_deadtime(cmd_dir, last_dir_q)) begin
              state_d  = StDeadtime;
              dt_cnt_d = DtW'(DEADTIME_TICKS);
            end else begin
              state_d    = StRun;
              last_dir_d = cmd_dir;
            end
          end
        end
      end
      StDeadtime: begin
        if (abort) begin
          state_d = StIdle;
        end else if (tick) begin
          if (dt_cnt_q == DtW'(1)) begin
            state_d    = StRun;
            last_dir_d = dir_q;
          end
          dt_cnt_d = dt_cnt_q - 1'b1;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (tick) begin
          if (dur_cnt_q == DUR_W'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
          dur_cnt_d = dur_cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d      = (state_d != StIdle);
    motiondir_d = (state_d == StRun) ? {1'b0, dir_d} : 4'd0;

`ifdef MOTION_SEQ_PWM_EN
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    speed_d   = accept ? cmd_speed : speed_q;
    // Compare against the counter value that will be live while this output is shown.
    if (pwm_cnt_d >= speed_d) begin
      motiondir_d = 4'd0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dt_cnt_q    <= '0;
      dur_cnt_q   <= '0;
      dir_q       <= MOT_REST;
      last_dir_q  <= MOT_REST;
      motiondir_q <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef MOTION_SEQ_PWM_EN
      pwm_cnt_q   <= '0;
      speed_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dt_cnt_q    <= dt_cnt_d;
      dur_cnt_q   <= dur_cnt_d;
      dir_q       <= dir_d;
      last_dir_q  <= last_dir_d;
      motiondir_q <= motiondir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef MOTION_SEQ_PWM_EN
      pwm_cnt_q   <= pwm_cnt_d;
      speed_q     <= speed_d;
`endif
    end
  end

  assign motiondir   = motiondir_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_bad_cmd = err_q;

endmodule

// File: tb/tb_motion_sequencer.sv
// Self-checking bench for motion_sequencer: timeline reference model plus directed literals.
module tb_motion_sequencer;

  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned TICK_HZ = 100;
  localparam int          TP      = CLK_HZ / TICK_HZ;
  localparam int          DT      = 2;
`ifdef MOTION_SEQ_PWM_EN
  localparam int          PWM_W   = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_dir = 3'd0;
  logic [7:0] cmd_dur = 8'd0;
  logic       abort = 1'b0;
  logic [3:0] motiondir;
  logic       busy, done, err_bad_cmd;
`ifdef MOTION_SEQ_PWM_EN
  logic [PWM_W-1:0] cmd_speed = '1;
`endif

  motion_sequencer #(
    .CLK_HZ         (CLK_HZ),
    .TICK_HZ        (TICK_HZ),
    .DUR_W          (8),
    .DEADTIME_TICKS (DT)
`ifdef MOTION_SEQ_PWM_EN
    ,
    .PWM_W          (PWM_W)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_dir     (cmd_dir),
    .cmd_dur     (cmd_dur),
`ifdef MOTION_SEQ_PWM_EN
    .cmd_speed   (cmd_speed),
`endif
    .abort       (abort),
    .motiondir   (motiondir),
    .busy        (busy),
    .done        (done),
    .err_bad_cmd (err_bad_cmd)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int obs_dir = 0, obs_done = 0, obs_err = 0;

  // Timeline model: m_c counts edges since reset release; tick edges are multiples of TP.
  // The current command drives during cycles [m_run_start, m_run_end).
  int         m_c = 0, m_run_start = 0, m_run_end = 0, m_busy_from = 0;
  int         m_done_at = -1, m_err_at = -1, m_speed = 0;
  logic [2:0] m_dir = 3'd0, m_last = 3'd0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d, t=%0t)", name, act, exp, m_c, $time);
    end
  endtask

  task automatic model_edge();
    int p;
    if (!rst_n) begin
      m_c = 0; m_run_start = 0; m_run_end = 0; m_busy_from = 0;
      m_done_at = -1; m_err_at = -1; m_dir = 3'd0; m_last = 3'd0; m_speed = 0;
    end else begin
      p   = m_c;
      m_c = m_c + 1;
      if (p >= m_busy_from && p < m_run_end) begin
        if (abort) begin
          m_run_end = m_c;
          if (m_done_at > p) m_done_at = -1;
        end
      end else if (cmd_valid && !abort) begin
        if (cmd_dir > 3'd4) begin
          m_err_at = m_c;
        end else if (cmd_dur == 8'd0) begin
          m_done_at = m_c;
        end else begin
          m_busy_from = m_c;
          m_dir       = cmd_dir;
`ifdef MOTION_SEQ_PWM_EN
          m_speed     = int'(cmd_speed);
`endif
          if (cmd_dir != 0 && m_last != 0 && cmd_dir != m_last) begin
            m_run_start = (m_c / TP + DT) * TP;
            m_run_end   = m_run_start + TP * int'(cmd_dur);
          end else begin
            m_run_start = m_c;
            m_run_end   = (m_c / TP + int'(cmd_dur)) * TP;
          end
          m_done_at = m_run_end;
        end
      end
      if (m_c == m_run_start && m_c < m_run_end) m_last = m_dir;
    end
  endtask

  task automatic compare();
    int e_md, e_busy, e_done, e_err, e_rdy;
    if (!rst_n) begin
      e_md = 0; e_busy = 0; e_done = 0; e_err = 0; e_rdy = 0;
    end else begin
      e_md = (m_c >= m_run_start && m_c < m_run_end) ? int'(m_dir) : 0;
`ifdef MOTION_SEQ_PWM_EN
      if ((m_c % (1 << PWM_W)) >= m_speed) e_md = 0;
`endif
      e_busy = (m_c >= m_busy_from && m_c < m_run_end) ? 1 : 0;
      e_done = (m_c == m_done_at) ? 1 : 0;
      e_err  = (m_c == m_err_at) ? 1 : 0;
      e_rdy  = (m_c >= m_run_end && !abort) ? 1 : 0;
    end
    chk("motiondir", int'(motiondir), e_md);
    chk("busy", int'(busy), e_busy);
    chk("done", int'(done), e_done);
    chk("err_bad_cmd", int'(err_bad_cmd), e_err);
    chk("cmd_ready", int'(cmd_ready), e_rdy);
    if (motiondir != 4'd0) obs_dir++;
    if (done) obs_done++;
    if (err_bad_cmd) obs_err++;
  endtask

  // One clock: model consumes inputs on the edge, outputs checked on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n, input int abort_rate);
    for (int i = 0; i < n; i++) begin
      step();
      abort = (abort_rate > 0) && ($urandom_range(abort_rate - 1) == 0);
    end
    abort = 1'b0;
  endtask

  task automatic send(input int d, input int dur);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_dir   = 3'(d);
    cmd_dur   = 8'(dur);
    abort     = 1'b0;
    #1;
    while (!cmd_ready && n < 400) begin
      step();
      #1;
      n++;
    end
    chk("accept_wait", int'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
    cmd_dir   = 3'($urandom);
    cmd_dur   = 8'($urandom);
  endtask

  task automatic wait_dir(input int d, input string name);
    int n = 0;
    while (int'(motiondir) != d && n < 100) begin
      step();
      n++;
    end
    chk(name, int'(motiondir), d);
  endtask

  initial begin
    int s_dir, s_done, s_err;
    #1 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    #1 chk("ready_after_reset", int'(cmd_ready), 1);

`ifndef MOTION_SEQ_PWM_EN
    s_dir = obs_dir; s_done = obs_done;
    send(1, 3);
    chk("fwd_latency", int'(motiondir), 1);
    chk("model_fwd_start", m_run_start, 1);
    chk("model_fwd_end", m_run_end, 30);
    run(35, 0);
    chk("fwd_dir_cycles", obs_dir - s_dir, 29);
    chk("fwd_done_count", obs_done - s_done, 1);

    s_dir = obs_dir;
    send(1, 2);
    chk("same_dir_no_deadtime", int'(motiondir), 1);
    run(20, 0);
    chk("same_dir_cycles", obs_dir - s_dir, 13);

    s_dir = obs_dir; s_done = obs_done;
    send(2, 1);
    chk("reverse_coast", int'(motiondir), 0);
    chk("reverse_busy", int'(busy), 1);
    chk("model_reverse_start", m_run_start, 70);
    run(30, 0);
    chk("reverse_dir_cycles", obs_dir - s_dir, 10);
    chk("reverse_done_count", obs_done - s_done, 1);

    s_dir = obs_dir; s_done = obs_done; s_err = obs_err;
    send(6, 5);
    chk("bad_code_err", int'(err_bad_cmd), 1);
    run(5, 0);
    send(3, 0);
    chk("zero_dur_done", int'(done), 1);
    chk("zero_dur_motiondir", int'(motiondir), 0);
    run(5, 0);
    chk("bad_zero_err_count", obs_err - s_err, 1);
    chk("bad_zero_done_count", obs_done - s_done, 1);
    chk("bad_zero_dir_cycles", obs_dir - s_dir, 0);

    send(2, 1);
    chk("last_dir_kept_after_zero_dur", int'(motiondir), 2);
    run(25, 0);

    send(4, 10);
    wait_dir(4, "left_run_reached");
    run(35, 0);
    s_done = obs_done;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_motiondir", int'(motiondir), 0);
    chk("abort_busy", int'(busy), 0);
    run(80, 0);
    chk("abort_no_done", obs_done - s_done, 0);

    send(1, 10);
    wait_dir(1, "fwd_after_abort_reached");
    run(5, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_motiondir", int'(motiondir), 0);
    chk("async_reset_busy", int'(busy), 0);
    step();
    step();
    rst_n = 1'b1;
`else
    send(3, 1);
    run(30, 0);
    cmd_speed = 2'd1;
    s_dir = obs_dir; s_done = obs_done;
    send(1, 2);
    run(50, 0);
    chk("pwm_quarter_duty_cycles", obs_dir - s_dir, 5);
    chk("pwm_quarter_done", obs_done - s_done, 1);
    cmd_speed = 2'd0;
    s_dir = obs_dir; s_done = obs_done;
    send(2, 2);
    run(50, 0);
    chk("pwm_zero_dir_cycles", obs_dir - s_dir, 0);
    chk("pwm_zero_done", obs_done - s_done, 1);
`endif

    for (int i = 0; i < 60; i++) begin
`ifdef MOTION_SEQ_PWM_EN
      cmd_speed = PWM_W'($urandom);
`endif
      send(int'($urandom_range(7)), int'($urandom_range(5)));
      run(int'($urandom_range(60)), 25);
    end
    run(80, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
